// File: rtl/led_pkg.sv
// Shared definitions for the LED PWM driver: pattern mode encodings,
// breathe direction states and a counter-width helper.
package led_pkg;

    typedef enum logic [1:0] {
        LED_OFF     = 2'b00,
        LED_STEADY  = 2'b01,
        LED_BLINK   = 2'b10,
        LED_BREATHE = 2'b11
    } led_mode_e;

    typedef enum logic {
        BR_UP   = 1'b0,
        BR_DOWN = 1'b1
    } br_state_e;

    // Width of a counter spanning 0..n-1, never less than one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 32'd1) ? $clog2(n) : 32'd1;
    endfunction

endpackage

// File: rtl/led_pwm_core.sv
// Prescaled PWM carrier: prescaler, period counter, boundary-loaded duty
// register and the registered compare that drives the LED pin.
module led_pwm_core
    import led_pkg::*;
#(
    parameter int PWM_BITS = 8,
    parameter int PRESCALE = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [PWM_BITS-1:0] duty,
    input  logic                load,
    output logic                boundary,
    output logic                led,
    output logic                period_start
);

    localparam int unsigned PS_W = cnt_width(PRESCALE);
    localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);
    localparam logic [PWM_BITS-1:0] PWM_MAX = {PWM_BITS{1'b1}};

    logic [PS_W-1:0]     pre_cnt_r;
    logic [PWM_BITS-1:0] pwm_cnt_r;
    logic [PWM_BITS-1:0] duty_q_r;
    logic                led_r;
    logic                period_start_r;
    logic                tick_s;
    logic                boundary_s;

    assign tick_s       = (pre_cnt_r == PS_LAST);
    assign boundary_s   = tick_s && (pwm_cnt_r == PWM_MAX);
    assign boundary     = boundary_s;
    assign led          = led_r;
    assign period_start = period_start_r;

    // Counters, duty latch and output registers; duty only changes at the wrap.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pre_cnt_r      <= '0;
            pwm_cnt_r      <= '0;
            duty_q_r       <= '0;
            led_r          <= 1'b0;
            period_start_r <= 1'b0;
        end else begin
            pre_cnt_r      <= tick_s ? '0 : pre_cnt_r + PS_W'(1);
            pwm_cnt_r      <= tick_s ? pwm_cnt_r + PWM_BITS'(1) : pwm_cnt_r;
            duty_q_r       <= load ? duty : duty_q_r;
            led_r          <= (pwm_cnt_r < duty_q_r);
            period_start_r <= boundary_s;
        end
    end

endmodule

// File: rtl/led_pwm_driver.sv
// LED pattern driver: OFF/STEADY/BLINK/BREATHE pattern state advanced once per
// PWM period, feeding the selected duty into the glitch-free PWM core.
module led_pwm_driver
    import led_pkg::*;
#(
    parameter int PWM_BITS      = 8,
    parameter int PRESCALE      = 16,
    parameter int BLINK_PERIODS = 64,
    parameter int BREATHE_STEP  = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [1:0]          mode,
    input  logic [PWM_BITS-1:0] brightness,
    output logic                led,
    output logic                period_start
);

    localparam int unsigned BL_W = cnt_width(BLINK_PERIODS);
    localparam int unsigned ST_W = cnt_width(BREATHE_STEP);
    localparam logic [BL_W-1:0] BL_LAST = BL_W'(BLINK_PERIODS - 1);
    localparam logic [ST_W-1:0] ST_LAST = ST_W'(BREATHE_STEP - 1);

    led_mode_e           mode_q_r, mode_q_s, mode_s;
    logic                blink_on_r, blink_on_s;
    logic [BL_W-1:0]     blink_cnt_r, blink_cnt_s;
    logic [PWM_BITS-1:0] level_r, level_s;
    br_state_e           br_state_r, br_state_s;
    logic [ST_W-1:0]     step_cnt_r, step_cnt_s;
    logic [PWM_BITS-1:0] duty_s;
    logic                boundary_s;

    assign mode_s = led_mode_e'(mode);

    // Pattern state register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mode_q_r    <= LED_OFF;
            blink_on_r  <= 1'b1;
            blink_cnt_r <= '0;
            level_r     <= '0;
            br_state_r  <= BR_UP;
            step_cnt_r  <= '0;
        end else begin
            mode_q_r    <= mode_q_s;
            blink_on_r  <= blink_on_s;
            blink_cnt_r <= blink_cnt_s;
            level_r     <= level_s;
            br_state_r  <= br_state_s;
            step_cnt_r  <= step_cnt_s;
        end
    end

    // Next pattern state and duty; inputs are only looked at on a period boundary.
    always_comb begin
        mode_q_s    = mode_q_r;
        blink_on_s  = blink_on_r;
        blink_cnt_s = blink_cnt_r;
        level_s     = level_r;
        br_state_s  = br_state_r;
        step_cnt_s  = step_cnt_r;
        duty_s      = '0;
        if (boundary_s) begin
            mode_q_s = mode_s;
            case (mode_s)
                LED_OFF:    duty_s = '0;
                LED_STEADY: duty_s = brightness;
                LED_BLINK: begin
                    if (mode_q_r != LED_BLINK) begin
                        blink_on_s  = 1'b1;
                        blink_cnt_s = '0;
                    end else if (blink_cnt_r == BL_LAST) begin
                        blink_cnt_s = '0;
                        blink_on_s  = !blink_on_r;
                    end else begin
                        blink_cnt_s = blink_cnt_r + BL_W'(1);
                    end
                    duty_s = blink_on_s ? brightness : '0;
                end
                LED_BREATHE: begin
                    if (mode_q_r != LED_BREATHE) begin
                        level_s    = '0;
                        br_state_s = BR_UP;
                        step_cnt_s = '0;
                    end else if (brightness == '0) begin
                        level_s    = '0;
                        br_state_s = BR_UP;
                    end else if (level_r > brightness) begin
                        // Target dropped below the current level: clamp and head down.
                        level_s    = brightness;
                        br_state_s = BR_DOWN;
                    end else if (step_cnt_r != ST_LAST) begin
                        step_cnt_s = step_cnt_r + ST_W'(1);
                    end else begin
                        step_cnt_s = '0;
                        if (br_state_r == BR_UP) begin
                            if (level_r < brightness) begin
                                level_s    = level_r + PWM_BITS'(1);
                                br_state_s = ((level_r + PWM_BITS'(1)) == brightness) ? BR_DOWN : BR_UP;
                            end else begin
                                br_state_s = BR_DOWN;
                            end
                        end else begin
                            if (level_r != '0) begin
                                level_s    = level_r - PWM_BITS'(1);
                                br_state_s = (level_r == PWM_BITS'(1)) ? BR_UP : BR_DOWN;
                            end else begin
                                br_state_s = BR_UP;
                            end
                        end
                    end
                    duty_s = level_s;
                end
                default: duty_s = '0;
            endcase
        end else begin
            duty_s = '0;
        end
    end

    led_pwm_core #(
        .PWM_BITS (PWM_BITS),
        .PRESCALE (PRESCALE)
    ) u_core (
        .clk          (clk),
        .rst_n        (rst_n),
        .duty         (duty_s),
        .load         (boundary_s),
        .boundary     (boundary_s),
        .led          (led),
        .period_start (period_start)
    );

endmodule

// File: tb/tb_led_pwm_driver.sv
// Directed bench for led_pwm_driver with a 4-bit, prescale-2 carrier
// (32 clk per PWM period); counts lit cycles per period.
module tb_led_pwm_driver;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] mode = 2'b00;
    logic [3:0] brightness = 4'd0;
    logic       led;
    logic       period_start;

    int total = 0;
    int bad = 0;

    led_pwm_driver #(
        .PWM_BITS      (4),
        .PRESCALE      (2),
        .BLINK_PERIODS (2),
        .BREATHE_STEP  (1)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .mode         (mode),
        .brightness   (brightness),
        .led          (led),
        .period_start (period_start)
    );

    always #5 clk = ~clk;

    // Wait (bounded) for a period_start pulse, sampled on falling edges.
    task automatic wait_ps();
        int n = 0;
        while (period_start !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (period_start !== 1'b1) begin
            total++;
            bad++;
            $display("FAIL ps_timeout: period_start=%b after %0d cycles, required 1", period_start, n);
        end
    endtask

    // Count lit cycles over one 32-clk period starting at its period_start cycle.
    task automatic measure(output int hi);
        wait_ps();
        hi = 0;
        for (int i = 0; i < 32; i++) begin
            if (led === 1'b1) hi++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        mode = 2'b01;
        brightness = 4'd8;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            total++;
            if (led !== 1'b0 || period_start !== 1'b0) begin
                bad++;
                $display("FAIL reset_hold: led=%b period_start=%b, required 0/0", led, period_start);
            end
        end
        brightness = 4'd4;
        rst_n = 1'b1;
    endtask

    task automatic test_steady();
        logic [3:0] bv [6] = '{4'd4, 4'd4, 4'd0, 4'd0, 4'd15, 4'd15};
        int         ev [6] = '{8, 8, 8, 0, 0, 30};
        int hi;
        for (int i = 0; i < 6; i++) begin
            brightness = bv[i];
            measure(hi);
            total++;
            if (hi !== ev[i]) begin
                bad++;
                $display("FAIL steady[%0d]: high=%0d, required %0d", i, hi, ev[i]);
            end
        end
    endtask

    task automatic test_midperiod_change();
        int hi;
        brightness = 4'd4;
        measure(hi);
        total++;
        if (hi !== 30) begin
            bad++;
            $display("FAIL mid_prev: high=%0d, required 30", hi);
        end
        wait_ps();
        hi = 0;
        for (int i = 0; i < 32; i++) begin
            if (i == 10) brightness = 4'd12;
            if (led === 1'b1) hi++;
            @(negedge clk);
        end
        total++;
        if (hi !== 8) begin
            bad++;
            $display("FAIL mid_current: high=%0d, required 8", hi);
        end
        measure(hi);
        total++;
        if (hi !== 24) begin
            bad++;
            $display("FAIL mid_next: high=%0d, required 24", hi);
        end
    endtask

    task automatic test_blink();
        int ev [7] = '{24, 16, 16, 0, 0, 16, 16};
        int hi;
        mode = 2'b10;
        brightness = 4'd8;
        for (int i = 0; i < 7; i++) begin
            measure(hi);
            total++;
            if (hi !== ev[i]) begin
                bad++;
                $display("FAIL blink[%0d]: high=%0d, required %0d", i, hi, ev[i]);
            end
        end
    endtask

    task automatic test_breathe();
        int ev [9] = '{0, 0, 2, 4, 6, 4, 2, 0, 2};
        int ed [4] = '{4, 2, 0, 2};
        int hi;
        mode = 2'b11;
        brightness = 4'd3;
        for (int i = 0; i < 9; i++) begin
            measure(hi);
            total++;
            if (hi !== ev[i]) begin
                bad++;
                $display("FAIL breathe[%0d]: high=%0d, required %0d", i, hi, ev[i]);
            end
        end
        brightness = 4'd1;
        for (int i = 0; i < 4; i++) begin
            measure(hi);
            total++;
            if (hi !== ed[i]) begin
                bad++;
                $display("FAIL breathe_drop[%0d]: high=%0d, required %0d", i, hi, ed[i]);
            end
        end
    endtask

    task automatic test_reset_mid_blink();
        int ev [3] = '{16, 16, 0};
        int hi;
        mode = 2'b10;
        brightness = 4'd8;
        measure(hi);
        wait_ps();
        repeat (5) @(negedge clk);
        total++;
        if (led !== 1'b1) begin
            bad++;
            $display("FAIL on_before_reset: led=%b, required 1", led);
        end
        rst_n = 1'b0;
        @(negedge clk);
        total++;
        if (led !== 1'b0 || period_start !== 1'b0) begin
            bad++;
            $display("FAIL reset_mid_on: led=%b period_start=%b, required 0/0", led, period_start);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            measure(hi);
            total++;
            if (hi !== ev[i]) begin
                bad++;
                $display("FAIL blink_after_reset[%0d]: high=%0d, required %0d", i, hi, ev[i]);
            end
        end
        repeat (6) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        total++;
        if (led !== 1'b0 || period_start !== 1'b0) begin
            bad++;
            $display("FAIL reset_mid_off: led=%b period_start=%b, required 0/0", led, period_start);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        measure(hi);
        total++;
        if (hi !== 16) begin
            bad++;
            $display("FAIL first_after_off_reset: high=%0d, required 16", hi);
        end
    endtask

    initial begin
        test_reset();
        test_steady();
        test_midperiod_change();
        test_blink();
        test_breathe();
        test_reset_mid_blink();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
